// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants for the memory request arbiter: opcodes, transaction kinds,
// IO region marker and the arbiter state encoding.
package mem_req_arbiter_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_FETCH = 2'b01;
  localparam logic [1:0] KIND_LOAD  = 2'b10;
  localparam logic [1:0] KIND_STORE = 2'b11;

  localparam logic [1:0] IO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester and memory-controller channel of the arbiter. The slave modport is
// the arbiter's view, the master modport is the surrounding pipeline/controller.
interface mem_req_arbiter_if;
  logic        rdy;
  logic        rollback;
  logic        io_buffer_full;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;

  logic        ld_req;
  logic [31:0] ld_addr;
  logic [5:0]  ld_op;
  logic        ld_ack;
  logic [31:0] ld_data;

  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [5:0]  st_op;
  logic        st_ack;

  logic        mc_valid;
  logic [1:0]  mc_kind;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [5:0]  mc_op;
  logic        mc_abort;
  logic        mc_done;
  logic [31:0] mc_rdata;

  modport slave (
    input  rdy, rollback, io_buffer_full,
    input  if_req, if_addr, ld_req, ld_addr, ld_op,
    input  st_req, st_addr, st_data, st_op,
    input  mc_done, mc_rdata,
    output if_ack, if_data, ld_ack, ld_data, st_ack,
    output mc_valid, mc_kind, mc_addr, mc_wdata, mc_op, mc_abort
  );

  modport master (
    output rdy, rollback, io_buffer_full,
    output if_req, if_addr, ld_req, ld_addr, ld_op,
    output st_req, st_addr, st_data, st_op,
    output mc_done, mc_rdata,
    input  if_ack, if_data, ld_ack, ld_data, st_ack,
    input  mc_valid, mc_kind, mc_addr, mc_wdata, mc_op, mc_abort
  );
endinterface

// File: rtl/mem_req_arbiter_prio_pick.sv
// Combinational eligibility and priority selection: store > load > fetch,
// except that a fetch that has lost STARVE_LIMIT rounds wins outright.
module mem_prio_pick
  import mem_req_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       st_req_i,
  input  logic [1:0] st_io_field_i,
  input  logic       ld_req_i,
  input  logic [1:0] ld_io_field_i,
  input  logic       if_req_i,
  input  logic       io_buffer_full_i,
  input  logic [3:0] starve_i,
  output logic [1:0] grant_kind_o
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic stBlocked;
  logic stEligible;
  logic ldEligible;

  // An IO load must not overtake an IO store that is stuck behind the IO buffer.
  always_comb begin
    stBlocked    = st_req_i && (st_io_field_i == IO_FIELD) && io_buffer_full_i;
    stEligible   = st_req_i && !stBlocked;
    ldEligible   = ld_req_i && !((ld_io_field_i == IO_FIELD) && stBlocked);
    grant_kind_o = KIND_NONE;
    if (if_req_i && (starve_i == LIMIT)) begin
      grant_kind_o = KIND_FETCH;
    end else if (stEligible) begin
      grant_kind_o = KIND_STORE;
    end else if (ldEligible) begin
      grant_kind_o = KIND_LOAD;
    end else if (if_req_i) begin
      grant_kind_o = KIND_FETCH;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Serialises icache fetches, LSB loads and ROB stores onto the single memory
// controller, one transaction at a time, with rollback and IO back-pressure.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int IO_BIT       = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_arbiter_if.slave bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [1:0]  grantKind;
  logic        abortable;
  logic        ackSuppress;

  logic        mcValid_q, mcValid_d;
  logic [1:0]  mcKind_q, mcKind_d;
  logic [31:0] mcAddr_q, mcAddr_d;
  logic [31:0] mcWdata_q, mcWdata_d;
  logic [5:0]  mcOp_q, mcOp_d;
  logic        mcAbort_q, mcAbort_d;
  logic        ifAck_q, ifAck_d;
  logic        ldAck_q, ldAck_d;
  logic        stAck_q, stAck_d;
  logic [31:0] ifData_q, ifData_d;
  logic [31:0] ldData_q, ldData_d;

  mem_prio_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .st_req_i        (bus.st_req),
    .st_io_field_i   (bus.st_addr[IO_BIT+1:IO_BIT]),
    .ld_req_i        (bus.ld_req),
    .ld_io_field_i   (bus.ld_addr[IO_BIT+1:IO_BIT]),
    .if_req_i        (bus.if_req),
    .io_buffer_full_i(bus.io_buffer_full),
    .starve_i        (starve_q),
    .grant_kind_o    (grantKind)
  );

  // Committed stores are never cancelled; only reads can be aborted.
  assign abortable = (mcKind_q != KIND_STORE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      starve_q  <= 4'd0;
      mcValid_q <= FALSE;
      mcKind_q  <= KIND_NONE;
      mcAddr_q  <= 32'd0;
      mcWdata_q <= 32'd0;
      mcOp_q    <= 6'd0;
      mcAbort_q <= FALSE;
      ifAck_q   <= FALSE;
      ldAck_q   <= FALSE;
      stAck_q   <= FALSE;
      ifData_q  <= 32'd0;
      ldData_q  <= 32'd0;
    end else if (bus.rdy) begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      mcValid_q <= mcValid_d;
      mcKind_q  <= mcKind_d;
      mcAddr_q  <= mcAddr_d;
      mcWdata_q <= mcWdata_d;
      mcOp_q    <= mcOp_d;
      mcAbort_q <= mcAbort_d;
      ifAck_q   <= ifAck_d;
      ldAck_q   <= ldAck_d;
      stAck_q   <= stAck_d;
      ifData_q  <= ifData_d;
      ldData_q  <= ldData_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.rollback && (grantKind != KIND_NONE)) begin
          state_d = ST_BUSY;
          if (grantKind == KIND_FETCH) begin
            starve_d = 4'd0;
          end else if (bus.if_req && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_BUSY: begin
        if (bus.rollback && abortable) begin
          state_d = ST_IDLE;
        end else if (bus.mc_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.rollback) begin
      starve_d = 4'd0;
    end
  end

  always_comb begin
    mcValid_d = mcValid_q;
    mcKind_d  = mcKind_q;
    mcAddr_d  = mcAddr_q;
    mcWdata_d = mcWdata_q;
    mcOp_d    = mcOp_q;
    mcAbort_d = FALSE;
    ifAck_d   = FALSE;
    ldAck_d   = FALSE;
    stAck_d   = FALSE;
    ifData_d  = ifData_q;
    ldData_d  = ldData_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.rollback && (grantKind != KIND_NONE)) begin
          mcValid_d = TRUE;
          mcKind_d  = grantKind;
          unique case (grantKind)
            KIND_STORE: begin
              mcAddr_d  = bus.st_addr;
              mcWdata_d = bus.st_data;
              mcOp_d    = bus.st_op;
            end
            KIND_LOAD: begin
              mcAddr_d  = bus.ld_addr;
              mcWdata_d = 32'd0;
              mcOp_d    = bus.ld_op;
            end
            default: begin
              mcAddr_d  = bus.if_addr;
              mcWdata_d = 32'd0;
              mcOp_d    = 6'd0;
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (bus.rollback && abortable) begin
          mcValid_d = FALSE;
          mcAbort_d = TRUE;
        end else if (bus.mc_done) begin
          mcValid_d = FALSE;
          unique case (mcKind_q)
            KIND_FETCH: begin
              ifAck_d  = TRUE;
              ifData_d = bus.mc_rdata;
            end
            KIND_LOAD: begin
              ldAck_d  = TRUE;
              ldData_d = bus.mc_rdata;
            end
            default: stAck_d = TRUE;
          endcase
        end
      end
      default: ;
    endcase
  end

  // A flush landing on the ack cycle of a read cancels that ack.
  assign ackSuppress = bus.rdy && bus.rollback && (state_q == ST_DONE) && abortable;

  assign bus.if_ack   = ifAck_q && !ackSuppress;
  assign bus.ld_ack   = ldAck_q && !ackSuppress;
  assign bus.st_ack   = stAck_q;
  assign bus.if_data  = ifData_q;
  assign bus.ld_data  = ldData_q;
  assign bus.mc_valid = mcValid_q;
  assign bus.mc_kind  = mcKind_q;
  assign bus.mc_addr  = mcAddr_q;
  assign bus.mc_wdata = mcWdata_q;
  assign bus.mc_op    = mcOp_q;
  assign bus.mc_abort = mcAbort_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter, built with STARVE_LIMIT=2 so the aging
// override is reachable after two lost rounds.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  mem_req_arbiter_if bus();

  mem_req_arbiter #(
    .STARVE_LIMIT(2),
    .IO_BIT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    bus.rdy = 1'b1; bus.rollback = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.ld_req = 1'b0; bus.ld_addr = 32'd0; bus.ld_op = 6'd0;
    bus.st_req = 1'b0; bus.st_addr = 32'd0; bus.st_data = 32'd0; bus.st_op = 6'd0;
    bus.mc_done = 1'b0; bus.mc_rdata = 32'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mc_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic finishTxn(input logic [31:0] rdata);
    bus.mc_done = 1'b1; bus.mc_rdata = rdata;
    tick();
    bus.mc_done = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    testsRun++;
    if ({bus.mc_valid, bus.mc_kind, bus.mc_abort, bus.if_ack, bus.ld_ack, bus.st_ack} !== 7'd0) begin
      testsFailed++; $display("[TB] FAIL reset_outputs got %b want 0", {bus.mc_valid, bus.mc_kind, bus.mc_abort, bus.if_ack, bus.ld_ack, bus.st_ack});
    end
    bus.ld_req = 1'b1; bus.ld_addr = 32'h40; bus.ld_op = OP_LW;
    tick();
    rst = 1'b1; bus.rollback = 1'b1;
    tick();
    rst = 1'b0; bus.rollback = 1'b0; bus.ld_req = 1'b0;
    testsRun++;
    if ({bus.mc_valid, bus.mc_abort, bus.mc_addr} !== 34'd0) begin
      testsFailed++; $display("[TB] FAIL reset_wins_busy got valid=%b abort=%b addr=%h want 0", bus.mc_valid, bus.mc_abort, bus.mc_addr);
    end
  endtask

  task automatic test_priority_order();
    doReset();
    bus.st_req = 1'b1; bus.st_addr = 32'h2000; bus.st_data = 32'h11223344; bus.st_op = OP_SW;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h100; bus.ld_op = OP_LW;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    tick();
    testsRun++;
    if ({bus.mc_valid, bus.mc_kind, bus.mc_addr, bus.mc_wdata, bus.mc_op} !== {1'b1, KIND_STORE, 32'h2000, 32'h11223344, OP_SW}) begin
      testsFailed++; $display("[TB] FAIL order_store got v=%b k=%b a=%h d=%h op=%0d want 1 11 2000 11223344 %0d", bus.mc_valid, bus.mc_kind, bus.mc_addr, bus.mc_wdata, bus.mc_op, OP_SW);
    end
    repeat (4) tick();
    finishTxn(32'd0);
    testsRun++;
    if ({bus.st_ack, bus.mc_valid} !== 2'b10) begin
      testsFailed++; $display("[TB] FAIL order_st_ack got ack=%b valid=%b want 1 0", bus.st_ack, bus.mc_valid);
    end
    bus.st_req = 1'b0;
    tick();
    testsRun++;
    if ({bus.st_ack, bus.mc_valid} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL order_st_ack_len got ack=%b valid=%b want 0 0", bus.st_ack, bus.mc_valid);
    end
    tick();
    testsRun++;
    if ({bus.mc_valid, bus.mc_kind, bus.mc_addr, bus.mc_op} !== {1'b1, KIND_LOAD, 32'h100, OP_LW}) begin
      testsFailed++; $display("[TB] FAIL order_load got v=%b k=%b a=%h op=%0d want 1 10 100 %0d", bus.mc_valid, bus.mc_kind, bus.mc_addr, bus.mc_op, OP_LW);
    end
    repeat (4) tick();
    finishTxn(32'hCAFEF00D);
    testsRun++;
    if ({bus.ld_ack, bus.ld_data} !== {1'b1, 32'hCAFEF00D}) begin
      testsFailed++; $display("[TB] FAIL order_ld_ack got ack=%b data=%h want 1 cafef00d", bus.ld_ack, bus.ld_data);
    end
    bus.ld_req = 1'b0;
    tick();
    testsRun++;
    if (bus.ld_ack !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL order_ld_ack_len got %b want 0", bus.ld_ack);
    end
    tick();
    testsRun++;
    if ({bus.mc_valid, bus.mc_kind, bus.mc_addr, bus.mc_op} !== {1'b1, KIND_FETCH, 32'h40, 6'd0}) begin
      testsFailed++; $display("[TB] FAIL order_fetch got v=%b k=%b a=%h op=%0d want 1 01 40 0", bus.mc_valid, bus.mc_kind, bus.mc_addr, bus.mc_op);
    end
    repeat (4) tick();
    finishTxn(32'h00000013);
    testsRun++;
    if ({bus.if_ack, bus.if_data} !== {1'b1, 32'h13}) begin
      testsFailed++; $display("[TB] FAIL order_if_ack got ack=%b data=%h want 1 00000013", bus.if_ack, bus.if_data);
    end
    bus.if_req = 1'b0;
    tick();
    testsRun++;
    if (bus.if_ack !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL order_if_ack_len got %b want 0", bus.if_ack);
    end
  endtask

  task automatic test_starvation();
    bit ok;
    doReset();
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h200; bus.ld_op = OP_LB;
    for (int n = 0; n < 2; n++) begin
      waitValid(ok);
      testsRun++;
      if (!ok || bus.mc_kind !== KIND_LOAD) begin
        testsFailed++; $display("[TB] FAIL starve_load%0d got ok=%b kind=%b want 1 10", n, ok, bus.mc_kind);
      end
      tick();
      finishTxn(32'(n));
      bus.ld_req = 1'b0;
      tick();
      bus.ld_req = 1'b1;
    end
    waitValid(ok);
    testsRun++;
    if (!ok || bus.mc_kind !== KIND_FETCH || bus.mc_addr !== 32'h80) begin
      testsFailed++; $display("[TB] FAIL starve_fetch got ok=%b kind=%b addr=%h want 1 01 80", ok, bus.mc_kind, bus.mc_addr);
    end
    tick();
    finishTxn(32'h77);
    testsRun++;
    if ({bus.if_ack, bus.if_data} !== {1'b1, 32'h77}) begin
      testsFailed++; $display("[TB] FAIL starve_if_ack got ack=%b data=%h want 1 00000077", bus.if_ack, bus.if_data);
    end
    bus.if_req = 1'b0;
    tick();
    bus.if_req = 1'b1;
    waitValid(ok);
    testsRun++;
    if (!ok || bus.mc_kind !== KIND_LOAD) begin
      testsFailed++; $display("[TB] FAIL starve_cleared got ok=%b kind=%b want 1 10", ok, bus.mc_kind);
    end
  endtask

  task automatic test_io_backpressure();
    bit ok;
    doReset();
    bus.io_buffer_full = 1'b1;
    bus.st_req = 1'b1; bus.st_addr = 32'h30000; bus.st_data = 32'hAB; bus.st_op = OP_SB;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h100; bus.ld_op = OP_LW;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    waitValid(ok);
    testsRun++;
    if (!ok || bus.mc_kind !== KIND_LOAD) begin
      testsFailed++; $display("[TB] FAIL io_load_first got ok=%b kind=%b want 1 10", ok, bus.mc_kind);
    end
    tick();
    finishTxn(32'h5);
    bus.ld_req = 1'b0;
    tick();
    waitValid(ok);
    testsRun++;
    if (!ok || bus.mc_kind !== KIND_FETCH) begin
      testsFailed++; $display("[TB] FAIL io_fetch_second got ok=%b kind=%b want 1 01", ok, bus.mc_kind);
    end
    tick();
    finishTxn(32'h6);
    bus.if_req = 1'b0;
    tick();
    bus.ld_req = 1'b1; bus.ld_addr = 32'h10030000;
    repeat (3) tick();
    testsRun++;
    if (bus.mc_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL io_all_blocked got valid=%b kind=%b want 0", bus.mc_valid, bus.mc_kind);
    end
    bus.io_buffer_full = 1'b0;
    tick();
    testsRun++;
    if ({bus.mc_valid, bus.mc_kind, bus.mc_addr, bus.mc_wdata} !== {1'b1, KIND_STORE, 32'h30000, 32'hAB}) begin
      testsFailed++; $display("[TB] FAIL io_store_released got v=%b k=%b a=%h d=%h want 1 11 30000 ab", bus.mc_valid, bus.mc_kind, bus.mc_addr, bus.mc_wdata);
    end
    tick();
    finishTxn(32'd0);
    testsRun++;
    if (bus.st_ack !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL io_st_ack got %b want 1", bus.st_ack);
    end
    bus.st_req = 1'b0;
    tick();
    waitValid(ok);
    testsRun++;
    if (!ok || bus.mc_kind !== KIND_LOAD || bus.mc_addr !== 32'h10030000) begin
      testsFailed++; $display("[TB] FAIL io_load_after got ok=%b kind=%b addr=%h want 1 10 10030000", ok, bus.mc_kind, bus.mc_addr);
    end
  endtask

  task automatic test_rollback_load();
    doReset();
    bus.ld_req = 1'b1; bus.ld_addr = 32'h1000; bus.ld_op = OP_LW;
    tick();
    tick();
    bus.rollback = 1'b1; bus.ld_req = 1'b0;
    tick();
    bus.rollback = 1'b0;
    testsRun++;
    if ({bus.mc_abort, bus.mc_valid, bus.ld_ack} !== 3'b100) begin
      testsFailed++; $display("[TB] FAIL rb_ld_abort got abort=%b valid=%b ack=%b want 1 0 0", bus.mc_abort, bus.mc_valid, bus.ld_ack);
    end
    finishTxn(32'h99);
    testsRun++;
    if ({bus.mc_abort, bus.mc_valid, bus.ld_ack} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL rb_ld_late_done got abort=%b valid=%b ack=%b want 0 0 0", bus.mc_abort, bus.mc_valid, bus.ld_ack);
    end
    tick();
    testsRun++;
    if (bus.ld_ack !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rb_ld_no_ack got %b want 0", bus.ld_ack);
    end
    bus.ld_req = 1'b1;
    tick();
    tick();
    bus.rollback = 1'b1; bus.mc_done = 1'b1; bus.ld_req = 1'b0;
    tick();
    bus.rollback = 1'b0; bus.mc_done = 1'b0;
    tick();
    testsRun++;
    if (bus.ld_ack !== 1'b0 || bus.mc_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rb_ld_same_done got ack=%b valid=%b want 0 0", bus.ld_ack, bus.mc_valid);
    end
    bus.ld_req = 1'b1;
    tick();
    tick();
    finishTxn(32'h44);
    bus.rollback = 1'b1;
    #1;
    testsRun++;
    if (bus.ld_ack !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rb_done_suppress got %b want 0", bus.ld_ack);
    end
    bus.ld_req = 1'b0;
    tick();
    bus.ld_req = 1'b1;
    tick();
    bus.rollback = 1'b0;
    testsRun++;
    if (bus.mc_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rb_idle_no_grant got %b want 0", bus.mc_valid);
    end
    tick();
    testsRun++;
    if (bus.mc_valid !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rb_idle_then_grant got %b want 1", bus.mc_valid);
    end
  endtask

  task automatic test_rollback_store();
    doReset();
    bus.st_req = 1'b1; bus.st_addr = 32'h2000; bus.st_data = 32'hDEADBEEF; bus.st_op = OP_SW;
    tick();
    tick();
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    testsRun++;
    if ({bus.mc_abort, bus.mc_valid, bus.mc_wdata} !== {2'b01, 32'hDEADBEEF}) begin
      testsFailed++; $display("[TB] FAIL rb_st_kept got abort=%b valid=%b wdata=%h want 0 1 deadbeef", bus.mc_abort, bus.mc_valid, bus.mc_wdata);
    end
    tick();
    tick();
    finishTxn(32'd0);
    bus.rollback = 1'b1;
    #1;
    testsRun++;
    if ({bus.st_ack, bus.mc_wdata} !== {1'b1, 32'hDEADBEEF}) begin
      testsFailed++; $display("[TB] FAIL rb_st_ack got ack=%b wdata=%h want 1 deadbeef", bus.st_ack, bus.mc_wdata);
    end
    bus.st_req = 1'b0;
    tick();
    bus.rollback = 1'b0;
  endtask

  task automatic test_rdy_stall();
    int badCycles;
    doReset();
    bus.ld_req = 1'b1; bus.ld_addr = 32'h3000; bus.ld_op = OP_LH;
    tick();
    tick();
    bus.rdy = 1'b0; bus.mc_done = 1'b1; bus.mc_rdata = 32'h1234;
    badCycles = 0;
    repeat (3) begin
      tick();
      if (bus.ld_ack !== 1'b0 || bus.mc_valid !== 1'b1) badCycles++;
    end
    testsRun++;
    if (badCycles != 0) begin
      testsFailed++; $display("[TB] FAIL stall_frozen got %0d bad cycles want 0", badCycles);
    end
    bus.rdy = 1'b1; bus.mc_done = 1'b0;
    tick();
    testsRun++;
    if ({bus.ld_ack, bus.mc_valid} !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL stall_resume got ack=%b valid=%b want 0 1", bus.ld_ack, bus.mc_valid);
    end
    finishTxn(32'h5678);
    testsRun++;
    if ({bus.ld_ack, bus.ld_data} !== {1'b1, 32'h5678}) begin
      testsFailed++; $display("[TB] FAIL stall_ack got ack=%b data=%h want 1 00005678", bus.ld_ack, bus.ld_data);
    end
    bus.rdy = 1'b0;
    tick();
    testsRun++;
    if (bus.ld_ack !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL stall_ack_held got %b want 1", bus.ld_ack);
    end
    bus.rdy = 1'b1; bus.ld_req = 1'b0;
    tick();
    testsRun++;
    if (bus.ld_ack !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL stall_ack_drop got %b want 0", bus.ld_ack);
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_priority_order();
    test_starvation();
    test_io_backpressure();
    test_rollback_load();
    test_rollback_store();
    test_rdy_stall();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
